// File: rtl/hcode_subshell_pkg.sv
// rtl/hcode_subshell_pkg.sv - shared mode encodings and widths for the subshell datapath
package hcode_subshell_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_INV  = 2'd1,
        MODE_INC  = 2'd2,
        MODE_REV  = 2'd3
    } mode_e;

    localparam int CNT_W  = 32;
    localparam int LANE_W = 32;

endpackage

// File: rtl/hcode_chan_buf.sv
// rtl/hcode_chan_buf.sv - one channel: ingest transform, elastic buffer, emitted-word counter
// ap_clk/ap_rst     : clock, synchronous active-high reset
// in_dout/in_empty_n/in_read   : host-side ap_fifo input (word taken while in_read high)
// out_din/out_full/out_write   : host-side ap_fifo output (push while out_write high)
// mode              : transform applied to words popped this cycle
// cnt_clr/cnt       : emitted-word counter and its clear pulse
module hcode_chan_buf
    import hcode_subshell_pkg::*;
#(
    parameter int W     = 128,
    parameter int DEPTH = 4
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic [W-1:0]     in_dout,
    input  logic             in_empty_n,
    output logic             in_read,
    output logic [W-1:0]     out_din,
    input  logic             out_full,
    output logic             out_write,
    input  logic [1:0]       mode,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int NL = W / LANE_W;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;
    logic          buf_full;
    logic          buf_empty;
    logic [W-1:0]  xf;

    assign buf_full  = (occ == (AW+1)'(DEPTH));
    assign buf_empty = (occ == '0);

    // Handshakes depend only on registered occupancy and the opposite side's
    // own flag, so there is no input-to-output combinational path.
    assign in_read   = in_empty_n & ~buf_full;
    assign out_write = ~buf_empty & ~out_full;
    assign out_din   = mem[rd_ptr];

    always_comb begin
        xf = in_dout;
        case (mode)
            MODE_INV: xf = ~in_dout;
            MODE_INC: begin
                for (int l = 0; l < NL; l++)
                    xf[l*LANE_W +: LANE_W] = in_dout[l*LANE_W +: LANE_W] + 1'b1;
            end
            MODE_REV: begin
                for (int l = 0; l < NL; l++)
                    xf[l*LANE_W +: LANE_W] = in_dout[(NL-1-l)*LANE_W +: LANE_W];
            end
            default: xf = in_dout;
        endcase
    end

    // Storage is deliberately not reset; stale entries are unreachable once
    // the pointers and occupancy are cleared.
    always_ff @(posedge ap_clk) begin
        if (in_read)
            mem[wr_ptr] <= xf;
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            cnt    <= '0;
        end else begin
            if (in_read)
                wr_ptr <= wr_ptr + 1'b1;
            if (out_write)
                rd_ptr <= rd_ptr + 1'b1;
            case ({in_read, out_write})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            // A clear coinciding with a write still counts that write.
            if (cnt_clr)
                cnt <= out_write ? CNT_W'(1) : '0;
            else if (out_write)
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hcode_subshell_nch.sv
// rtl/hcode_subshell_nch.sv - NCH independent ap_fifo channels with transform and word counters
// ap_clk/ap_rst                      : clock, synchronous active-high reset
// in_r_dout/in_r_empty_n/in_r_read   : input streams, channel c at [c*W +: W] / bit c
// out_r_din/out_r_full/out_r_write   : output streams, channel c at [c*W +: W] / bit c
// mode                               : channel c transform at [2c +: 2]
// cnt_clr/cnt                        : channel c counter clear / count at [32c +: 32]
module hcode_subshell_nch
    import hcode_subshell_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int W     = 128,
    parameter int DEPTH = 4
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic [NCH*W-1:0]     in_r_dout,
    input  logic [NCH-1:0]       in_r_empty_n,
    output logic [NCH-1:0]       in_r_read,
    output logic [NCH*W-1:0]     out_r_din,
    input  logic [NCH-1:0]       out_r_full,
    output logic [NCH-1:0]       out_r_write,
    input  logic [2*NCH-1:0]     mode,
    input  logic [NCH-1:0]       cnt_clr,
    output logic [CNT_W*NCH-1:0] cnt
);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        hcode_chan_buf #(
            .W     (W),
            .DEPTH (DEPTH)
        ) u_chan (
            .ap_clk     (ap_clk),
            .ap_rst     (ap_rst),
            .in_dout    (in_r_dout[c*W +: W]),
            .in_empty_n (in_r_empty_n[c]),
            .in_read    (in_r_read[c]),
            .out_din    (out_r_din[c*W +: W]),
            .out_full   (out_r_full[c]),
            .out_write  (out_r_write[c]),
            .mode       (mode[2*c +: 2]),
            .cnt_clr    (cnt_clr[c]),
            .cnt        (cnt[c*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_hcode_subshell_nch.sv
// tb/tb_hcode_subshell_nch.sv - randomized self-checking bench for hcode_subshell_nch
module tb_hcode_subshell_nch;

    localparam int NCH   = 4;
    localparam int W     = 128;
    localparam int DEPTH = 4;
    localparam int NL    = W / 32;

    logic                ap_clk;
    logic                ap_rst;
    logic [NCH*W-1:0]    in_r_dout;
    logic [NCH-1:0]      in_r_empty_n;
    logic [NCH-1:0]      in_r_read;
    logic [NCH*W-1:0]    out_r_din;
    logic [NCH-1:0]      out_r_full;
    logic [NCH-1:0]      out_r_write;
    logic [2*NCH-1:0]    mode;
    logic [NCH-1:0]      cnt_clr;
    logic [32*NCH-1:0]   cnt;

    hcode_subshell_nch #(.NCH(NCH), .W(W), .DEPTH(DEPTH)) dut (
        .ap_clk       (ap_clk),
        .ap_rst       (ap_rst),
        .in_r_dout    (in_r_dout),
        .in_r_empty_n (in_r_empty_n),
        .in_r_read    (in_r_read),
        .out_r_din    (out_r_din),
        .out_r_full   (out_r_full),
        .out_r_write  (out_r_write),
        .mode         (mode),
        .cnt_clr      (cnt_clr),
        .cnt          (cnt)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    // Bench-side sources, sinks and reference model.
    logic [W-1:0] src_q [NCH][$];
    logic [W-1:0] mq    [NCH][$];
    logic [31:0]  mcnt  [NCH];
    logic         avail [NCH];
    logic         full_v[NCH];
    logic         clr   [NCH];
    int           mode_v[NCH];
    int           rd_seen[NCH];
    int           wr_seen[NCH];
    int           n_chk;
    int           n_fail;

    function automatic logic [W-1:0] rnd_word();
        logic [W-1:0] r;
        for (int l = 0; l < NL; l++) r[32*l +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [W-1:0] xform(logic [W-1:0] d, int m);
        logic [W-1:0] r;
        r = d;
        if (m == 1) r = ~d;
        if (m == 2) for (int l = 0; l < NL; l++) r[32*l +: 32] = d[32*l +: 32] + 32'd1;
        if (m == 3) for (int l = 0; l < NL; l++) r[32*l +: 32] = d[32*(NL-1-l) +: 32];
        return r;
    endfunction

    task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_seen();
        for (int c = 0; c < NCH; c++) begin
            rd_seen[c] = 0;
            wr_seen[c] = 0;
        end
    endtask

    // One clock cycle: drive inputs, compare every output with the model,
    // advance the model by what the handshake rules say happens at the edge.
    task automatic step();
        logic         er;
        logic         ew;
        logic [W-1:0] word;
        logic [W-1:0] junk;
        for (int c = 0; c < NCH; c++) begin
            in_r_empty_n[c]     = avail[c] && (src_q[c].size() > 0);
            in_r_dout[c*W +: W] = (src_q[c].size() > 0) ? src_q[c][0] : rnd_word();
            out_r_full[c]       = full_v[c];
            mode[2*c +: 2]      = 2'(mode_v[c]);
            cnt_clr[c]          = clr[c];
        end
        #1;
        for (int c = 0; c < NCH; c++) begin
            er = avail[c] && (src_q[c].size() > 0) && (mq[c].size() < DEPTH);
            ew = (mq[c].size() > 0) && !full_v[c];
            chk($sformatf("in_r_read[%0d]", c), W'(in_r_read[c]), W'(er));
            chk($sformatf("out_r_write[%0d]", c), W'(out_r_write[c]), W'(ew));
            chk($sformatf("cnt[%0d]", c), W'(cnt[32*c +: 32]), W'(mcnt[c]));
            if (mq[c].size() > 0)
                chk($sformatf("out_r_din[%0d]", c), out_r_din[c*W +: W], mq[c][0]);
            if (in_r_read[c]) rd_seen[c]++;
            if (out_r_write[c]) wr_seen[c]++;
            word = '0;
            if (er) word = src_q[c].pop_front();
            if (ap_rst) begin
                mq[c].delete();
                mcnt[c] = '0;
            end else begin
                if (ew) junk = mq[c].pop_front();
                if (clr[c]) mcnt[c] = ew ? 32'd1 : 32'd0;
                else if (ew) mcnt[c] = mcnt[c] + 32'd1;
                if (er) mq[c].push_back(xform(word, mode_v[c]));
            end
        end
        @(negedge ap_clk);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        ap_rst = 1'b1;
        in_r_dout = '0;
        in_r_empty_n = '0;
        out_r_full = '0;
        mode = '0;
        cnt_clr = '0;
        for (int c = 0; c < NCH; c++) begin
            mcnt[c] = '0; avail[c] = 1'b1; full_v[c] = 1'b0; clr[c] = 1'b0; mode_v[c] = 0;
        end
        clear_seen();
        repeat (2) @(negedge ap_clk);

        // Reset state
        step();
        step();
        ap_rst = 1'b0;
        chk("reset_cnt", W'(cnt), W'(0));
        chk("reset_write", W'(out_r_write), W'(0));

        // Pass, lane increment with wrap, lane reverse; write at t+1
        src_q[0].push_back(128'h00000003_00000002_00000001_00000000);
        src_q[1].push_back(128'h00000005_00000004_FFFFFFFF_00000007);
        src_q[2].push_back(128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
        mode_v[0] = 0; mode_v[1] = 2; mode_v[2] = 3; mode_v[3] = 0;
        step();
        chk("lat_write", W'(out_r_write), W'(4'b0111));
        chk("pass_ch0", out_r_din[0 +: W], 128'h00000003_00000002_00000001_00000000);
        chk("inc_ch1", out_r_din[W +: W], 128'h00000006_00000005_00000000_00000008);
        chk("rev_ch2", out_r_din[2*W +: W], 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD);
        step();
        chk("cnt_ch0_one", W'(cnt[31:0]), W'(1));
        chk("cnt_ch3_idle", W'(cnt[127:96]), W'(0));

        // Backpressure on ch3: fills to DEPTH, then drains in order
        full_v[3] = 1'b1;
        for (int i = 0; i < 6; i++) src_q[3].push_back(rnd_word());
        clear_seen();
        repeat (8) step();
        chk("bp_reads", W'(rd_seen[3]), W'(4));
        chk("bp_read_low", W'(in_r_read[3]), W'(0));
        full_v[3] = 1'b0;
        clear_seen();
        repeat (6) step();
        chk("bp_drain_writes", W'(wr_seen[3]), W'(6));

        // All channels streaming 100 words at full rate
        for (int c = 0; c < NCH; c++) begin
            clr[c] = 1'b1;
            mode_v[c] = $urandom_range(0, 3);
            for (int i = 0; i < 100; i++) src_q[c].push_back(rnd_word());
        end
        step();
        for (int c = 0; c < NCH; c++) clr[c] = 1'b0;
        clear_seen();
        repeat (101) step();
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("stream_writes[%0d]", c), W'(wr_seen[c]), W'(100));
            chk($sformatf("stream_cnt[%0d]", c), W'(cnt[32*c +: 32]), W'(100));
        end

        // Clear coinciding with a write, then clear alone
        src_q[0].push_back(rnd_word());
        step();
        clr[0] = 1'b1;
        step();
        clr[0] = 1'b0;
        chk("clr_with_write", W'(cnt[31:0]), W'(1));
        clr[0] = 1'b1;
        step();
        clr[0] = 1'b0;
        chk("clr_alone", W'(cnt[31:0]), W'(0));

        // Reset with three words buffered on ch0
        full_v[0] = 1'b1;
        for (int i = 0; i < 3; i++) src_q[0].push_back(rnd_word());
        repeat (3) step();
        ap_rst = 1'b1;
        step();
        ap_rst = 1'b0;
        full_v[0] = 1'b0;
        clear_seen();
        step();
        chk("rst_flush_write", W'(out_r_write[0]), W'(0));
        chk("rst_flush_cnt", W'(cnt[31:0]), W'(0));
        repeat (3) step();
        chk("rst_flush_never", W'(wr_seen[0]), W'(0));

        // Randomized traffic with mode changes, clears and occasional reset
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NCH; c++) begin
                avail[c]  = ($urandom_range(0, 3) != 0);
                full_v[c] = ($urandom_range(0, 3) == 0);
                clr[c]    = ($urandom_range(0, 63) == 0);
                if ($urandom_range(0, 15) == 0) mode_v[c] = $urandom_range(0, 3);
                if (src_q[c].size() < 2) src_q[c].push_back(rnd_word());
            end
            ap_rst = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
